// File: rtl/spike_mac_pipe_if.sv
// spike_mac_pipe_if: valid/ready beat interface for the synaptic MAC pipeline.
//   master : spike/weight producer and sum consumer (drives in_*, out_ready)
//   slave  : spike_mac_pipe (drives in_ready, out_valid, out_sum, out_sat)
//   in_valid/in_ready/in_first  input beat handshake and window start
//   spikes_in[N_IN]             spike bits, bit i gates weight i
//   weights_in[N_IN*W_W]        signed weight i at [i*W_W +: W_W]
//   out_valid/out_ready         output beat handshake
//   out_sum[ACC_W]              signed running saturated window sum
//   out_sat                     sticky saturation flag for the window
interface spike_mac_pipe_if #(
   parameter int unsigned N_IN  = 25,
   parameter int unsigned W_W   = 16,
   parameter int unsigned ACC_W = 24
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_first;
   logic [N_IN-1:0]       spikes_in;
   logic [N_IN*W_W-1:0]   weights_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_W-1:0]      out_sum;
   logic                  out_sat;

   modport master (
      output in_valid, in_first, spikes_in, weights_in, out_ready,
      input  in_ready, out_valid, out_sum, out_sat
   );

   modport slave (
      input  in_valid, in_first, spikes_in, weights_in, out_ready,
      output in_ready, out_valid, out_sum, out_sat
   );
endinterface

// File: rtl/spike_mac_pipe.sv
// spike_mac_pipe: pipelined spike-gated weight reduction with saturating
// membrane-potential accumulation.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    spike_mac_pipe_if.slave (in_* beat in, out_* sum out)
// Pipeline: input register, clog2(N_IN) registered adder-tree levels, then
// the accumulate/saturate register. The whole pipe stalls together on
// in_ready = out_ready | ~out_valid.
module spike_mac_pipe #(
   parameter int unsigned N_IN  = 25,
   parameter int unsigned W_W   = 16,
   parameter int unsigned ACC_W = 24
) (
   input logic             clk,
   input logic             rst_n,
   spike_mac_pipe_if.slave bus
);

   // Operand count at tree level k (level 0 = gated products).
   function automatic int unsigned cnt_at(input int unsigned k);
      int unsigned c;
      c = N_IN;
      for (int unsigned j = 0; j < k; j++) c = (c + 1) / 2;
      return c;
   endfunction

   // Bit offset of registered level k (k >= 1) inside tree_w.
   function automatic int unsigned off_at(input int unsigned k);
      int unsigned o;
      o = 0;
      for (int unsigned j = 1; j < k; j++) o = o + cnt_at(j) * (W_W + j);
      return o;
   endfunction

   localparam int unsigned L      = $clog2(N_IN);
   localparam int unsigned TREE_W = W_W + L;
   localparam int unsigned OFF_L  = off_at(L);
   localparam int unsigned TOT_W  = OFF_L + TREE_W;
   // Sum width covers both the accumulator and a full-range tree result.
   localparam int unsigned SUM_W  = ((ACC_W > TREE_W) ? ACC_W : TREE_W) + 1;

   localparam logic signed [SUM_W-1:0] MAX_T = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_T = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] MAX_O = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_O = {1'b1, {(ACC_W-1){1'b0}}};

   logic                    advance_c;
   logic [L:0]              vld_q;
   logic [L:0]              first_q;
   logic [N_IN-1:0]         spk_q;
   logic [N_IN*W_W-1:0]     w_q;
   logic [N_IN*W_W-1:0]     prod_c;
   wire  [TOT_W-1:0]        tree_w;
   logic signed [TREE_W-1:0] tree_c;
   logic                    out_valid_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    sat_q;
   logic signed [SUM_W-1:0] base_c;
   logic signed [SUM_W-1:0] t_c;
   logic signed [ACC_W-1:0] sum_c;
   logic                    sat_c;
   logic                    sat_nxt_c;

   assign advance_c     = bus.out_ready | ~out_valid_q;
   assign bus.in_ready  = advance_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = acc_q;
   assign bus.out_sat   = sat_q;

   // Valid/first shift alongside the data; index 0 is the input register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= '0;
         first_q <= '0;
      end else if (advance_c) begin
         vld_q   <= {vld_q[L-1:0], bus.in_valid};
         first_q <= {first_q[L-1:0], bus.in_first};
      end
   end

   // Input data register; contents are don't-care while its valid is low.
   always_ff @(posedge clk) begin
      if (advance_c) begin
         spk_q <= bus.spikes_in;
         w_q   <= bus.weights_in;
      end
   end

   // Spike-gated products.
   always_comb begin
      prod_c = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         prod_c[i*W_W +: W_W] = spk_q[i] ? w_q[i*W_W +: W_W] : '0;
      end
   end

   // Registered binary adder tree; odd tail operand passes through widened.
   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int unsigned WD   = W_W + k;
      localparam int unsigned CNT  = cnt_at(k);
      localparam int unsigned PCNT = cnt_at(k - 1);
      localparam int unsigned OFF  = off_at(k);
      localparam int unsigned POFF = off_at(k - 1);

      for (genvar i = 0; i < CNT; i++) begin : g_n
         logic signed [WD-1:0] q;
         logic signed [WD-2:0] a_c;

         if (k == 1) begin : g_src0
            assign a_c = prod_c[(2*i)*W_W +: W_W];
         end else begin : g_srcn
            assign a_c = tree_w[POFF + (2*i)*(WD-1) +: WD-1];
         end

         if (2*i + 1 < PCNT) begin : g_add
            logic signed [WD-2:0] b_c;
            if (k == 1) begin : g_srcb0
               assign b_c = prod_c[(2*i+1)*W_W +: W_W];
            end else begin : g_srcbn
               assign b_c = tree_w[POFF + (2*i+1)*(WD-1) +: WD-1];
            end
            always_ff @(posedge clk) begin
               if (advance_c) q <= WD'(a_c) + WD'(b_c);
            end
         end else begin : g_pass
            always_ff @(posedge clk) begin
               if (advance_c) q <= WD'(a_c);
            end
         end

         assign tree_w[OFF + i*WD +: WD] = q;
      end
   end

   assign tree_c = tree_w[OFF_L +: TREE_W];

   // Window accumulate with signed clamp and sticky saturation.
   always_comb begin
      base_c    = '0;
      if (!first_q[L]) base_c = SUM_W'(acc_q);
      t_c       = base_c + SUM_W'(tree_c);
      sum_c     = ACC_W'(t_c);
      sat_c     = 1'b0;
      if (t_c > MAX_T) begin
         sum_c = MAX_O;
         sat_c = 1'b1;
      end else if (t_c < MIN_T) begin
         sum_c = MIN_O;
         sat_c = 1'b1;
      end
      sat_nxt_c = sat_c | (first_q[L] ? 1'b0 : sat_q);
   end

   // Output register; bubbles leave the accumulator untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
      end else if (advance_c) begin
         out_valid_q <= vld_q[L];
         if (vld_q[L]) begin
            acc_q <= sum_c;
            sat_q <= sat_nxt_c;
         end
      end
   end

endmodule

// File: tb/tb_spike_mac_pipe.sv
// tb_spike_mac_pipe: directed bench for spike_mac_pipe. Instance a uses
// ACC_W=24, instance b uses ACC_W=18 for clamp cases. Outputs are collected
// on the falling edge whenever a beat is consumed.
module tb_spike_mac_pipe;
   localparam int unsigned N = 25;
   localparam int unsigned W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spike_mac_pipe_if #(.N_IN(N), .W_W(W), .ACC_W(24)) bus_a ();
   spike_mac_pipe_if #(.N_IN(N), .W_W(W), .ACC_W(18)) bus_b ();

   spike_mac_pipe #(.N_IN(N), .W_W(W), .ACC_W(24)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   spike_mac_pipe #(.N_IN(N), .W_W(W), .ACC_W(18)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   int     n_chk = 0;
   int     n_bad = 0;
   int     cyc   = 0;
   longint qa_sum[$];
   longint qb_sum[$];
   int     qa_sat[$];
   int     qb_sat[$];
   int     qa_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
         qa_sum.push_back(longint'($signed(bus_a.out_sum)));
         qa_sat.push_back(int'(bus_a.out_sat));
         qa_cyc.push_back(cyc);
      end
      if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
         qb_sum.push_back(longint'($signed(bus_b.out_sum)));
         qb_sat.push_back(int'(bus_b.out_sat));
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] fill_w(input logic [W-1:0] w);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = w;
      return r;
   endfunction

   // Lane 0 carries w; other lanes hold junk that the spikes must gate off.
   function automatic logic [N*W-1:0] lane0_w(input logic [W-1:0] w);
      logic [N*W-1:0] r;
      r = fill_w(16'h5A5A);
      r[W-1:0] = w;
      return r;
   endfunction

   task automatic send(input bit sel, input bit first, input logic [N-1:0] spk,
                       input logic [N*W-1:0] w);
      bit ok;
      int n;
      n = 0;
      if (sel) begin
         bus_b.in_valid   = 1'b1;
         bus_b.in_first   = first;
         bus_b.spikes_in  = spk;
         bus_b.weights_in = w;
      end else begin
         bus_a.in_valid   = 1'b1;
         bus_a.in_first   = first;
         bus_a.spikes_in  = spk;
         bus_a.weights_in = w;
      end
      do begin
         @(negedge clk);
         ok = sel ? bus_b.in_ready : bus_a.in_ready;
         tick();
         n++;
      end while (!ok && n < 50);
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input bit sel);
      if (sel) bus_b.in_valid = 1'b0;
      else     bus_a.in_valid = 1'b0;
   endtask

   task automatic expect_out(input bit sel, input string tag, input longint es,
                             input int esat, output int c);
      int     n;
      longint s;
      int     st;
      n = 0;
      c = 0;
      while ((sel ? qb_sum.size() : qa_sum.size()) == 0 && n < 60) begin
         tick();
         n++;
      end
      if ((sel ? qb_sum.size() : qa_sum.size()) == 0) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         if (sel) begin
            s  = qb_sum.pop_front();
            st = qb_sat.pop_front();
         end else begin
            s  = qa_sum.pop_front();
            st = qa_sat.pop_front();
            c  = qa_cyc.pop_front();
         end
         check({tag, "_sum"}, s, es);
         check({tag, "_sat"}, longint'(st), longint'(esat));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int             c0, c1, c2, hi;
      logic [N-1:0]   sp;
      logic [N*W-1:0] w;
      longint         exp_st[10];
      exp_st = '{100, 300, 600, 1000, 1500, 2100, 2800, 3600, 4500, 5500};

      bus_a.in_valid = 1'b0; bus_a.in_first = 1'b0; bus_a.spikes_in = '0;
      bus_a.weights_in = '0; bus_a.out_ready = 1'b1;
      bus_b.in_valid = 1'b0; bus_b.in_first = 1'b0; bus_b.spikes_in = '0;
      bus_b.weights_in = '0; bus_b.out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_out_valid", longint'(bus_a.out_valid), 0);
      check("rst_out_sum",   longint'(bus_a.out_sum), 0);
      check("rst_out_sat",   longint'(bus_a.out_sat), 0);
      check("rst_in_ready",  longint'(bus_a.in_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(); tick();

      // All spikes, all weights 1: sum 25, check 7-stage latency
      send(1'b0, 1'b1, '1, fill_w(16'd1));
      idle(1'b0);
      repeat (5) tick();
      check("lat_early", longint'(bus_a.out_valid), 0);
      tick();
      check("lat_7", longint'(bus_a.out_valid), 1);
      expect_out(1'b0, "ones", 25, 0, c0);

      // Single spike on odd passthrough lane 24, weight -300
      sp = '0;
      sp[24] = 1'b1;
      w = fill_w(16'h1234);
      w[24*W +: W] = 16'hFED4;
      send(1'b0, 1'b1, sp, w);
      idle(1'b0);
      expect_out(1'b0, "lane24", -300, 0, c0);

      // Three back-to-back accumulating beats
      send(1'b0, 1'b1, N'(1), lane0_w(16'h7FFF));
      send(1'b0, 1'b0, N'(1), lane0_w(16'h7FFF));
      send(1'b0, 1'b0, N'(1), lane0_w(16'h7FFF));
      idle(1'b0);
      expect_out(1'b0, "b2b0", 32767, 0, c0);
      expect_out(1'b0, "b2b1", 65534, 0, c1);
      expect_out(1'b0, "b2b2", 98301, 0, c2);
      check("b2b_gap01", longint'(c1 - c0), 1);
      check("b2b_gap12", longint'(c2 - c1), 1);

      // All-zero spikes: valid beat, sum unchanged
      send(1'b0, 1'b0, '0, fill_w(16'h7FFF));
      idle(1'b0);
      expect_out(1'b0, "zero_spk", 98301, 0, c0);

      // Stream 10 beats with a 5-cycle downstream stall
      hi = 0;
      fork
         begin
            for (int i = 0; i < 10; i++)
               send(1'b0, (i == 0), N'(1), lane0_w(W'((i + 1) * 100)));
            idle(1'b0);
         end
         begin
            repeat (8) tick();
            bus_a.out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               if (bus_a.in_ready) hi++;
               tick();
            end
            bus_a.out_ready = 1'b1;
         end
      join
      check("stall_in_ready_hi", longint'(hi), 0);
      for (int i = 0; i < 10; i++) expect_out(1'b0, $sformatf("stall%0d", i), exp_st[i], 0, c0);
      repeat (12) tick();
      check("stall_extra", longint'(qa_sum.size()), 0);

      // Reset with 4 beats in flight
      for (int i = 0; i < 4; i++) send(1'b0, 1'b0, N'(1), lane0_w(16'd9));
      idle(1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", longint'(bus_a.out_valid), 0);
      check("rst_mid_sum",   longint'(bus_a.out_sum), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(1'b0, 1'b0, N'(1), lane0_w(16'd7));
      idle(1'b0);
      expect_out(1'b0, "post_rst", 7, 0, c0);
      repeat (12) tick();
      check("rst_ghost", longint'(qa_sum.size()), 0);

      // ACC_W=18 instance: positive clamp, window restart, negative clamp
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0, '1, fill_w(16'h7FFF));
      idle(1'b1);
      for (int i = 0; i < 3; i++) expect_out(1'b1, $sformatf("clamp_hi%0d", i), 131071, 1, c0);
      send(1'b1, 1'b1, N'(1), lane0_w(16'd5));
      idle(1'b1);
      expect_out(1'b1, "restart", 5, 0, c0);
      send(1'b1, 1'b1, '1, fill_w(16'h8000));
      idle(1'b1);
      expect_out(1'b1, "clamp_lo", -131072, 1, c0);
      send(1'b1, 1'b0, N'(1), lane0_w(16'd5));
      idle(1'b1);
      expect_out(1'b1, "sticky", -131067, 1, c0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
